motor_ramp_sequencer: RTL

- Sequences the sorter's drive motors (shared IN1/IN2/ENA and IN3/IN4/ENB bridge pair).
- Accepts run/stop/direction/duty commands over a valid/ready handshake.
- Ramps PWM duty one step per PWM period (soft start and soft stop).
- Enforces a coast dead-time before any direction reversal.
- Provides a synchronous emergency stop. Replaces the fixed-duty, switch-driven motor drive.

---
 rtl/motor_pkg.sv | 17 +
 rtl/pwm_tick_gen.sv | 43 ++++
 rtl/motor_ramp_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared types and constants for the motor ramp sequencer.
package motor_pkg;

   typedef enum logic [1:0] {IDLE, RAMP, HOLD, DEAD} state_e;

   localparam int unsigned PWM_STEPS = 100;
   localparam int unsigned DUTY_W    = 7;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // Saturate a requested duty at full scale.
   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
      return (d > DUTY_W'(PWM_STEPS)) ? DUTY_W'(PWM_STEPS) : d;
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Duty-step divider and 0..99 PWM phase counter.
module pwm_tick_gen
   import motor_pkg::*;
#(
   parameter int unsigned STEP_DIV = 5  // clocks per duty step, must be >= 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              step_tick,
   output logic              period_end,
   output logic [DUTY_W-1:0] pwm_cnt
);

   localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic [DIV_W-1:0]  div_q, div_d;
   logic [DUTY_W-1:0] cnt_q, cnt_d;

   // Tick on the last divider count; the period ends on the tick that wraps the phase.
   always_comb begin
      step_tick  = (div_q == DIV_W'(STEP_DIV - 1));
      period_end = step_tick && (cnt_q == DUTY_W'(PWM_STEPS - 1));
      div_d      = step_tick ? '0 : div_q + DIV_W'(1);
      cnt_d      = cnt_q;
      if (step_tick) begin
         cnt_d = period_end ? '0 : cnt_q + DUTY_W'(1);
      end
   end

   // Divider and phase registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

   assign pwm_cnt = cnt_q;

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Soft-start/soft-stop H-bridge sequencer with reversal dead-time and emergency stop.
module motor_ramp_sequencer
   import motor_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 100_000_000,
   parameter int unsigned PWM_FREQ     = 500,
   parameter int unsigned RAMP_STEP    = 1,
   parameter int unsigned DEAD_PERIODS = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_run,
   input  logic              cmd_dir,
   input  logic [DUTY_W-1:0] cmd_duty,
   input  logic              estop,
   output logic              motor_in1,
   output logic              motor_in2,
   output logic              motor_en,
   output logic [DUTY_W-1:0] cur_duty,
   output logic              busy
);

   localparam int unsigned STEP_DIV = CLK_FREQ / (PWM_FREQ * PWM_STEPS);
   localparam int unsigned DEAD_W   = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

   state_e            state_q, state_d;
   logic [DUTY_W-1:0] cur_q, cur_d;
   logic [DUTY_W-1:0] tgt_q, tgt_d;
   logic              pdir_q, pdir_d;
   logic              adir_q, adir_d;
   logic [DEAD_W-1:0] dead_q, dead_d;
   logic              en_q;

   logic              period_end;
   logic [DUTY_W-1:0] pwm_cnt;
   logic              tick_unused;  // sequencing only needs period boundaries

   logic              accept;
   logic [DUTY_W-1:0] cmd_target;
   logic [DUTY_W-1:0] goal;
   logic [DUTY_W:0]   up;
   logic [DUTY_W-1:0] stepped;

   pwm_tick_gen #(
      .STEP_DIV (STEP_DIV)
   ) u_tick (
      .clk        (clk),
      .rst        (rst),
      .step_tick  (tick_unused),
      .period_end (period_end),
      .pwm_cnt    (pwm_cnt)
   );

   // State and datapath registers; motor_en is re-registered every clock from the phase compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         tgt_q   <= '0;
         pdir_q  <= DIR_FWD;
         adir_q  <= DIR_FWD;
         dead_q  <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         pdir_q  <= pdir_d;
         adir_q  <= adir_d;
         dead_q  <= dead_d;
         en_q    <= !estop && (pwm_cnt < cur_q);
      end
   end

   // Next-state: ramp toward the goal at period boundaries, estop overrides everything.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      tgt_d      = tgt_q;
      pdir_d     = pdir_q;
      adir_d     = adir_q;
      dead_d     = dead_q;
      accept     = cmd_valid && cmd_ready;
      cmd_target = cmd_run ? clamp_duty(cmd_duty) : '0;
      // A pending reversal ramps to zero first.
      goal       = (pdir_q != adir_q) ? '0 : tgt_q;
      up         = {1'b0, cur_q} + (DUTY_W+1)'(RAMP_STEP);
      if (cur_q < goal) begin
         stepped = (up > {1'b0, goal}) ? goal : up[DUTY_W-1:0];
      end else if (cur_q > goal) begin
         stepped = ({1'b0, cur_q} > ({1'b0, goal} + (DUTY_W+1)'(RAMP_STEP))) ?
                   cur_q - DUTY_W'(RAMP_STEP) : goal;
      end else begin
         stepped = cur_q;
      end

      unique case (state_q)
         IDLE: begin
            if (accept && (cmd_target != '0)) begin
               adir_d  = cmd_dir;
               state_d = RAMP;
            end
         end
         RAMP: begin
            if (period_end) begin
               cur_d = stepped;
               if (stepped == goal) begin
                  if ((goal == '0) && (pdir_q != adir_q)) begin
                     state_d = DEAD;
                     dead_d  = '0;
                  end else if (goal == '0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (accept && ((cmd_target != tgt_q) || (cmd_dir != adir_q))) begin
               state_d = RAMP;
            end
         end
         DEAD: begin
            if (period_end) begin
               if (dead_q == DEAD_W'(DEAD_PERIODS - 1)) begin
                  dead_d  = '0;
                  adir_d  = pdir_q;
                  state_d = (tgt_q == '0) ? IDLE : RAMP;
               end else begin
                  dead_d = dead_q + DEAD_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Last accepted command wins; a same-cycle boundary stepped with the old target above.
      if (accept) begin
         tgt_d  = cmd_target;
         pdir_d = cmd_dir;
      end

      if (estop) begin
         state_d = IDLE;
         cur_d   = '0;
         tgt_d   = '0;
         dead_d  = '0;
      end
   end

   // Outputs: bridge is driven only while ramping or holding, coast otherwise.
   always_comb begin
      cmd_ready = (state_q != DEAD) && !estop;
      motor_in1 = ((state_q == RAMP) || (state_q == HOLD)) && (adir_q == DIR_FWD);
      motor_in2 = ((state_q == RAMP) || (state_q == HOLD)) && (adir_q == DIR_REV);
      busy      = (state_q == RAMP) || (state_q == DEAD);
      motor_en  = en_q;
      cur_duty  = cur_q;
   end

endmodule
